// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/return sequencer in front of the CSR block.
// Takes synchronous exceptions, mret and synchronized level interrupts, flushes
// the pipeline, writes mstatus/mepc/mcause/mtval, then redirects the fetch PC.
// Optional build macro: TRAP_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 1); without it every trap goes to the mtvec base.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    // pipeline events
    input  logic            exc_valid,
    input  logic [XLEN-2:0] exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            bnd_valid,
    input  logic [XLEN-1:0] bnd_pc,
    input  logic            pipe_empty,
    // platform interrupt levels (asynchronous)
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic            irq_ext,
    // CSR field reads
    input  logic            csr_rd_mstatus_mie,
    input  logic            csr_rd_mstatus_mpie,
    input  logic            csr_rd_mie_msie,
    input  logic            csr_rd_mie_mtie,
    input  logic            csr_rd_mie_meie,
    input  logic [XLEN-3:0] csr_rd_mtvec_base,
    input  logic [1:0]      csr_rd_mtvec_mode,
    input  logic [XLEN-1:0] csr_rd_mepc_mepc,
    // CSR hardware writes
    output logic            csr_trap,
    output logic            csr_mstatus_wen,
    output logic            csr_wr_mstatus_mie,
    output logic            csr_wr_mstatus_mpie,
    output logic [XLEN-1:0] csr_wr_mepc_mepc,
    output logic [XLEN-1:0] csr_wr_mtval_mtval,
    output logic [XLEN-2:0] csr_wr_mcause_exception_code,
    output logic            csr_wr_mcause_interrupt,
    output logic            csr_set_mip_msip,
    output logic            csr_set_mip_mtip,
    output logic            csr_set_mip_meip,
    // pipeline control
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_WRITE    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_IRQ  = 2'd1,
        KIND_MRET = 2'd2
    } kind_t;

    // Interrupt bit order in the vectors below: [0]=sw, [1]=timer, [2]=ext
    localparam logic [XLEN-2:0] CAUSE_SW    = (XLEN-1)'(3);
    localparam logic [XLEN-2:0] CAUSE_TIMER = (XLEN-1)'(7);
    localparam logic [XLEN-2:0] CAUSE_EXT   = (XLEN-1)'(11);

    state_t          state;
    kind_t           kind_reg;
    logic [XLEN-2:0] cause_reg;
    logic            intr_reg;
    logic [XLEN-1:0] epc_reg;
    logic [XLEN-1:0] tval_reg;
    logic [XLEN-1:0] target_reg;

    logic [2:0]      irq_vec;
    logic [2:0]      sync1_reg;
    logic [2:0]      sync2_reg;
    logic [2:0]      sync_prev_reg;
    logic [2:0]      mip_pulse_reg;

    logic [2:0]      irq_en;
    logic [2:0]      irq_elig;
    logic            irq_any;
    logic [XLEN-2:0] irq_cause;
    logic [XLEN-1:0] base_addr;
    logic [XLEN-1:0] irq_target;

    assign irq_vec = {irq_ext, irq_timer, irq_sw};

    // Two-flop synchronizer per request, then a registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            sync_prev_reg <= '0;
            mip_pulse_reg <= '0;
        end else begin
            sync1_reg     <= irq_vec;
            sync2_reg     <= sync1_reg;
            sync_prev_reg <= sync2_reg;
            mip_pulse_reg <= sync2_reg & ~sync_prev_reg;
        end
    end

    assign csr_set_mip_msip = mip_pulse_reg[0];
    assign csr_set_mip_mtip = mip_pulse_reg[1];
    assign csr_set_mip_meip = mip_pulse_reg[2];

    // Eligibility and fixed priority: ext > sw > timer
    always_comb begin
        irq_en    = {csr_rd_mie_meie, csr_rd_mie_mtie, csr_rd_mie_msie};
        irq_elig  = sync2_reg & irq_en & {3{csr_rd_mstatus_mie & bnd_valid}};
        irq_any   = |irq_elig;
        irq_cause = CAUSE_TIMER;
        if (irq_elig[2]) begin
            irq_cause = CAUSE_EXT;
        end else if (irq_elig[0]) begin
            irq_cause = CAUSE_SW;
        end
    end

    assign base_addr = {csr_rd_mtvec_base, 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vectored mode only applies to interrupts; offset is 4*cause, wrapping at XLEN
    logic [XLEN-1:0] vec_offset;
    assign vec_offset = XLEN'(irq_cause) << 2;
    assign irq_target = (csr_rd_mtvec_mode == 2'b01) ? (base_addr + vec_offset) : base_addr;
`else
    // Mode field is intentionally ignored in this build
    logic unused_mode;
    assign unused_mode = ^csr_rd_mtvec_mode;
    assign irq_target  = base_addr;
`endif

    assign busy = (state != ST_IDLE);

    // Sequencer: capture event, flush, write CSRs, redirect; all outputs registered
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state                        <= ST_IDLE;
            kind_reg                     <= KIND_EXC;
            cause_reg                    <= '0;
            intr_reg                     <= 1'b0;
            epc_reg                      <= '0;
            tval_reg                     <= '0;
            target_reg                   <= '0;
            flush                        <= 1'b0;
            csr_trap                     <= 1'b0;
            csr_mstatus_wen              <= 1'b0;
            csr_wr_mstatus_mie           <= 1'b0;
            csr_wr_mstatus_mpie          <= 1'b0;
            csr_wr_mepc_mepc             <= '0;
            csr_wr_mtval_mtval           <= '0;
            csr_wr_mcause_exception_code <= '0;
            csr_wr_mcause_interrupt      <= 1'b0;
            redirect_valid               <= 1'b0;
            redirect_pc                  <= '0;
        end else begin
            // Write strobes and values are only meaningful for the single WRITE cycle
            csr_trap                     <= 1'b0;
            csr_mstatus_wen              <= 1'b0;
            csr_wr_mstatus_mie           <= 1'b0;
            csr_wr_mstatus_mpie          <= 1'b0;
            csr_wr_mepc_mepc             <= '0;
            csr_wr_mtval_mtval           <= '0;
            csr_wr_mcause_exception_code <= '0;
            csr_wr_mcause_interrupt      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        kind_reg   <= KIND_EXC;
                        cause_reg  <= exc_code;
                        intr_reg   <= 1'b0;
                        epc_reg    <= exc_pc;
                        tval_reg   <= exc_tval;
                        target_reg <= base_addr;
                        flush      <= 1'b1;
                        state      <= ST_FLUSH;
                    end else if (mret_valid) begin
                        kind_reg   <= KIND_MRET;
                        cause_reg  <= '0;
                        intr_reg   <= 1'b0;
                        epc_reg    <= '0;
                        tval_reg   <= '0;
                        target_reg <= '0;
                        flush      <= 1'b1;
                        state      <= ST_FLUSH;
                    end else if (irq_any) begin
                        kind_reg   <= KIND_IRQ;
                        cause_reg  <= irq_cause;
                        intr_reg   <= 1'b1;
                        epc_reg    <= bnd_pc;
                        tval_reg   <= '0;
                        target_reg <= irq_target;
                        flush      <= 1'b1;
                        state      <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    if (pipe_empty) begin
                        flush           <= 1'b0;
                        csr_mstatus_wen <= 1'b1;
                        state           <= ST_WRITE;
                        if (kind_reg == KIND_MRET) begin
                            csr_wr_mstatus_mie  <= csr_rd_mstatus_mpie;
                            csr_wr_mstatus_mpie <= 1'b1;
                        end else begin
                            csr_trap                     <= 1'b1;
                            csr_wr_mstatus_mie           <= 1'b0;
                            csr_wr_mstatus_mpie          <= csr_rd_mstatus_mie;
                            csr_wr_mepc_mepc             <= epc_reg;
                            csr_wr_mtval_mtval           <= tval_reg;
                            csr_wr_mcause_exception_code <= cause_reg;
                            csr_wr_mcause_interrupt      <= intr_reg;
                        end
                    end
                end

                ST_WRITE: begin
                    // mret returns to whatever mepc holds during the write cycle
                    redirect_valid <= 1'b1;
                    redirect_pc    <= (kind_reg == KIND_MRET) ? csr_rd_mepc_mepc : target_reg;
                    state          <= ST_REDIRECT;
                end

                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                        state          <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
